// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: default sizes, state
// encoding and small state-decoding helpers.
package fft_pkg;

  localparam int N_LOG2_DEF  = 12;
  localparam int AD_W_DEF    = 10;
  localparam int ADDR_W_DEF  = 16;
  localparam int TMO_CYC_DEF = 65536;
  localparam int TMO_CNT_W   = 17;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPT    = 3'd1;
  localparam logic [2:0] ST_CFG_FWD = 3'd2;
  localparam logic [2:0] ST_RUN_FWD = 3'd3;
  localparam logic [2:0] ST_CFG_INV = 3'd4;
  localparam logic [2:0] ST_RUN_INV = 3'd5;
  localparam logic [2:0] ST_PLAY    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  function automatic logic st_busy(input logic [2:0] s);
    return (s != ST_IDLE) && (s != ST_ERR);
  endfunction

  function automatic logic st_run(input logic [2:0] s);
    return (s == ST_RUN_FWD) || (s == ST_RUN_INV);
  endfunction

  function automatic logic st_cfg(input logic [2:0] s);
    return (s == ST_CFG_FWD) || (s == ST_CFG_INV);
  endfunction

endpackage

// File: rtl/fft_tmo_cnt.sv
// Clearable saturating wait counter; hit flags the cycle in which the
// TMO_CYC-th consecutive enabled cycle is being spent.
module fft_tmo_cnt
  import fft_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int CNT_W   = TMO_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_AT = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // cnt_reg holds the number of enabled cycles already completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign hit = en && (cnt_reg >= HIT_AT);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: capture N samples, run the FFT core forward then inverse,
// and stream the reconstructed frame to the playback buffer.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEF,
  parameter int AD_W    = AD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              fft_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic [AD_W-1:0]   ad_data,
  input  logic [ADDR_W-1:0] ram_add_real,
  input  logic [ADDR_W-1:0] ram_add_img,
  output logic              cap_we,
  output logic [N_LOG2-1:0] cap_addr,
  output logic [AD_W-1:0]   cap_wdata,
  output logic              fft_cfg_valid,
  input  logic              fft_cfg_ready,
  output logic              fft_inv,
  output logic [ADDR_W-1:0] fft_base_real,
  output logic [ADDR_W-1:0] fft_base_img,
  input  logic              fft_done,
  output logic              play_en,
  output logic [N_LOG2-1:0] play_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        state
);

  localparam logic [N_LOG2-1:0] LAST = {N_LOG2{1'b1}};

  logic [2:0]        state_next;
  logic [N_LOG2-1:0] cap_cnt_reg;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_hit;

  assign tmo_en  = st_run(state);
  assign tmo_clr = st_run(state_next) && (state_next != state);

  fft_tmo_cnt #(
    .TMO_CYC (TMO_CYC),
    .CNT_W   (TMO_CNT_W)
  ) u_tmo (
    .clk (fft_clk),
    .rst (sys_rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .hit (tmo_hit)
  );

  // abort overrides every transition; done wins over a simultaneous timeout
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_next = ST_CAPT;
        ST_CAPT:    if (cap_cnt_reg == LAST) state_next = ST_CFG_FWD;
        ST_CFG_FWD: if (fft_cfg_ready) state_next = ST_RUN_FWD;
        ST_RUN_FWD: begin
          if (fft_done)     state_next = ST_CFG_INV;
          else if (tmo_hit) state_next = ST_ERR;
        end
        ST_CFG_INV: if (fft_cfg_ready) state_next = ST_RUN_INV;
        ST_RUN_INV: begin
          if (fft_done)     state_next = ST_PLAY;
          else if (tmo_hit) state_next = ST_ERR;
        end
        ST_PLAY: begin
          if (play_addr == LAST) state_next = cont_mode ? ST_CAPT : ST_IDLE;
        end
        ST_ERR:     if (start) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      cap_cnt_reg   <= '0;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      fft_cfg_valid <= 1'b0;
      fft_inv       <= 1'b0;
      fft_base_real <= '0;
      fft_base_img  <= '0;
      play_en       <= 1'b0;
      play_addr     <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= st_busy(state_next);
      cap_we     <= 1'b0;
      frame_done <= 1'b0;

      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              fft_base_real <= ram_add_real;
              fft_base_img  <= ram_add_img;
            end
          end
          // writes trail the state by one cycle so the sample is taken on the write edge
          ST_CAPT: begin
            cap_we      <= 1'b1;
            cap_addr    <= cap_cnt_reg;
            cap_wdata   <= ad_data;
            cap_cnt_reg <= cap_cnt_reg + N_LOG2'(1);
          end
          ST_PLAY: begin
            if (play_addr == LAST) frame_done <= 1'b1;
            else                   play_addr  <= play_addr + N_LOG2'(1);
          end
          ST_ERR: begin
            if (start) err <= 1'b0;
          end
          default: ;
        endcase
      end

      if ((state_next == ST_CAPT) && (state != ST_CAPT)) cap_cnt_reg <= '0;

      // handshake and playback strobes are aligned with the state itself
      fft_cfg_valid <= st_cfg(state_next);
      play_en       <= (state_next == ST_PLAY);
      if (state_next == ST_CFG_FWD) fft_inv <= 1'b0;
      if (state_next == ST_CFG_INV) fft_inv <= 1'b1;
      if ((state_next == ST_PLAY) && (state != ST_PLAY)) play_addr <= '0;
      if ((state_next == ST_ERR) && (state != ST_ERR))   err       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl with N=16, TMO_CYC=32; an event log of
// writes, handshakes and playback is compared against the frame rules.
module tb_fft_frame_ctrl;

  localparam int NL  = 4;
  localparam int N   = 16;
  localparam int AW  = 10;
  localparam int BW  = 16;
  localparam int TMO = 32;

  logic          fft_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, cont_mode = 1'b0;
  logic [AW-1:0] ad_data = '0;
  logic [BW-1:0] ram_add_real = '0, ram_add_img = '0;
  logic          cap_we;
  logic [NL-1:0] cap_addr;
  logic [AW-1:0] cap_wdata;
  logic          fft_cfg_valid, fft_inv;
  logic          fft_cfg_ready = 1'b0;
  logic [BW-1:0] fft_base_real, fft_base_img;
  logic          fft_done = 1'b0;
  logic          play_en, busy, frame_done, err;
  logic [NL-1:0] play_addr;
  logic [2:0]    state;

  fft_frame_ctrl #(.N_LOG2(NL), .AD_W(AW), .ADDR_W(BW), .TMO_CYC(TMO)) dut (
    .fft_clk(fft_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .cont_mode(cont_mode), .ad_data(ad_data), .ram_add_real(ram_add_real),
    .ram_add_img(ram_add_img), .cap_we(cap_we), .cap_addr(cap_addr),
    .cap_wdata(cap_wdata), .fft_cfg_valid(fft_cfg_valid),
    .fft_cfg_ready(fft_cfg_ready), .fft_inv(fft_inv),
    .fft_base_real(fft_base_real), .fft_base_img(fft_base_img),
    .fft_done(fft_done), .play_en(play_en), .play_addr(play_addr),
    .busy(busy), .frame_done(frame_done), .err(err), .state(state)
  );

  always #5 fft_clk = ~fft_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_pass = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // event log of the current frame
  int cyc = 0;
  int w_addr[$], w_data[$], w_exp[$], w_cyc[$];
  int p_addr[$], p_cyc[$], fd_cyc[$], acc_inv[$], cfg_len[$];
  int st_cnt[8];
  int cur_len = 0, inv_flip = 0, busy_bad = 0;
  logic cur_inv = 1'b0;

  // behaviour of the surrounding core for the current frame
  int rdy_fwd, rdy_inv, done_fwd, done_inv;
  int rdy_left = 0, done_left = -1, ramp_v = 0, start_cyc = 0;
  bit ramp = 0, spur = 0;

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_exp.delete(); w_cyc.delete();
    p_addr.delete(); p_cyc.delete(); fd_cyc.delete(); acc_inv.delete(); cfg_len.delete();
    foreach (st_cnt[i]) st_cnt[i] = 0;
    cur_len = 0; inv_flip = 0;
  endtask

  task automatic begin_frame(input int rf, input int ri, input int df, input int di,
                             input bit rmp, input bit sp);
    rdy_fwd = rf; rdy_inv = ri; done_fwd = df; done_inv = di;
    rdy_left = rf; done_left = -1; ramp = rmp; spur = sp;
    clear_log();
  endtask

  task automatic step();
    logic [AW-1:0] ad_edge;
    bit hs;
    logic hs_inv;
    ad_edge = ad_data;
    hs      = fft_cfg_valid && fft_cfg_ready;
    hs_inv  = fft_inv;
    @(posedge fft_clk); #1;
    cyc++;
    if (cap_we) begin
      w_addr.push_back(int'(cap_addr)); w_data.push_back(int'(cap_wdata));
      w_exp.push_back(int'(ad_edge));   w_cyc.push_back(cyc);
    end
    if (play_en) begin p_addr.push_back(int'(play_addr)); p_cyc.push_back(cyc); end
    if (frame_done) fd_cyc.push_back(cyc);
    st_cnt[state]++;
    if (busy != ((state != 3'd0) && (state != 3'd7))) busy_bad++;
    if (hs) begin
      acc_inv.push_back(int'(hs_inv)); cfg_len.push_back(cur_len); cur_len = 0;
      if (!hs_inv) begin rdy_left = rdy_inv; done_left = done_fwd; end
      else done_left = done_inv;
    end
    if (fft_cfg_valid) begin
      if (cur_len == 0) cur_inv = fft_inv;
      else if (fft_inv != cur_inv) inv_flip++;
      cur_len++;
    end
    // drive inputs for the next edge
    ad_data = ramp ? AW'(ramp_v) : AW'($urandom);
    ramp_v++;
    fft_done = 1'b0;
    if (done_left > 0) begin
      done_left--;
      if (done_left == 0) begin fft_done = 1'b1; done_left = -1; end
    end
    if (spur && (((state == 3'd1) && (cap_addr == NL'(5))) || (state == 3'd4))) fft_done = 1'b1;
    if (fft_cfg_valid) begin
      if (rdy_left > 0) begin fft_cfg_ready = 1'b0; rdy_left--; end
      else fft_cfg_ready = 1'b1;
    end else begin
      fft_cfg_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_start();
    start = 1'b1; ramp_v = 0;
    step();
    start = 1'b0; start_cyc = cyc;
    check_val("start_state", state, 1);
  endtask

  task automatic run_to(input int kind);
    int n = 0;
    while (!((kind == 0 && (state == 3'd0 || state == 3'd7)) || (kind == 1 && fd_cyc.size() > 0))
           && n < 2000) begin
      step(); n++;
    end
    if (n >= 2000) check_val("run_budget", n, 0);
  endtask

  task automatic check_frame(input int exp_capt);
    int bad_a = 0, bad_d = 0, bad_g = 0, pb_a = 0, pb_g = 0;
    check_val("wr_count", w_addr.size(), N);
    foreach (w_addr[i]) begin
      if (w_addr[i] != i) bad_a++;
      if (w_data[i] != w_exp[i] || (ramp && w_data[i] != i)) bad_d++;
      if (i > 0 && w_cyc[i] != w_cyc[i-1] + 1) bad_g++;
    end
    check_val("wr_addr_seq", bad_a, 0);
    check_val("wr_data", bad_d, 0);
    check_val("wr_gaps", bad_g, 0);
    check_val("cfg_count", acc_inv.size(), 2);
    if (acc_inv.size() == 2) begin
      check_val("cfg0_inv", acc_inv[0], 0);
      check_val("cfg1_inv", acc_inv[1], 1);
      check_val("cfg0_valid_len", cfg_len[0], rdy_fwd + 1);
      check_val("cfg1_valid_len", cfg_len[1], rdy_inv + 1);
    end
    check_val("inv_stable", inv_flip, 0);
    check_val("play_count", p_addr.size(), N);
    foreach (p_addr[i]) begin
      if (p_addr[i] != i) pb_a++;
      if (i > 0 && p_cyc[i] != p_cyc[i-1] + 1) pb_g++;
    end
    check_val("play_addr_seq", pb_a, 0);
    check_val("play_gaps", pb_g, 0);
    check_val("frame_done_count", fd_cyc.size(), 1);
    if (fd_cyc.size() == 1 && p_cyc.size() > 0)
      check_val("frame_done_time", fd_cyc[0], p_cyc[p_cyc.size()-1] + 1);
    check_val("capt_cycles", st_cnt[1], exp_capt);
    check_val("cfg_fwd_cycles", st_cnt[2], rdy_fwd + 1);
    check_val("run_fwd_cycles", st_cnt[3], done_fwd);
    check_val("cfg_inv_cycles", st_cnt[4], rdy_inv + 1);
    check_val("run_inv_cycles", st_cnt[5], done_inv);
    check_val("play_cycles", st_cnt[6], N);
  endtask

  int len1, len2;
  logic [BW-1:0] br, bi;

  initial begin
    ram_add_real = 16'hABCD; ram_add_img = 16'h1234;
    repeat (3) @(posedge fft_clk);
    #1;
    check_val("rst_state", state, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_outs", {cap_we, fft_cfg_valid, play_en, frame_done, err, fft_inv}, 0);
    check_val("rst_base", {fft_base_real, fft_base_img}, 0);
    sys_rst = 1'b0;
    repeat (2) step();
    check_val("idle_hold", state, 0);

    // basic frame, ramp samples
    br = BW'($urandom); bi = BW'($urandom); ram_add_real = br; ram_add_img = bi;
    begin_frame(0, 0, 5, 5, 1, 0);
    do_start();
    check_val("base_real", fft_base_real, br);
    check_val("base_img", fft_base_img, bi);
    run_to(0);
    check_frame(N);
    if (w_cyc.size() > 0) check_val("first_write_time", w_cyc[0], start_cyc + 1);
    len1 = cyc - start_cyc;
    check_val("s1_end_state", state, 0);

    // ready held low in CFG_FWD
    begin_frame(7, 0, 5, 5, 0, 0);
    do_start();
    run_to(0);
    check_frame(N);

    // timeout in RUN_FWD, then start clears the error
    begin_frame(0, 0, -1, 5, 0, 0);
    do_start();
    run_to(0);
    check_val("tmo_state", state, 7);
    check_val("tmo_run_cycles", st_cnt[3], TMO);
    check_val("tmo_err", err, 1);
    repeat (3) step();
    check_val("err_sticky", {err, state}, {1'b1, 3'd7});
    start = 1'b1; step(); start = 1'b0;
    check_val("err_clear_state", state, 0);
    check_val("err_clear_err", err, 0);
    step();
    check_val("err_start_no_frame", state, 0);

    // done on the very cycle the timeout is reached
    begin_frame(0, 0, TMO, 1, 0, 0);
    do_start();
    run_to(0);
    check_frame(N);
    check_val("done_at_tmo_err", err, 0);

    // abort together with start on the 10th capture cycle
    begin_frame(0, 0, 5, 5, 0, 0);
    do_start();
    repeat (9) step();
    check_val("abort_pre_state", state, 1);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check_val("abort_state", state, 0);
    check_val("abort_we", cap_we, 0);
    check_val("abort_busy", busy, 0);
    repeat (5) step();
    check_val("abort_writes", w_addr.size(), 9);
    check_val("abort_idle", state, 0);

    // continuous mode with base inputs changing mid-frame
    br = BW'($urandom); bi = BW'($urandom); ram_add_real = br; ram_add_img = bi;
    begin_frame(0, 0, 5, 5, 0, 0);
    cont_mode = 1'b1;
    do_start();
    repeat (4) step();
    ram_add_real = ~br; ram_add_img = ~bi;
    run_to(1);
    check_val("cont_recapture", state, 1);
    check_frame(N + 1);
    clear_log();
    cont_mode = 1'b0;
    run_to(0);
    check_frame(N - 1);
    check_val("cont_base_real", fft_base_real, br);
    check_val("cont_base_img", fft_base_img, bi);
    check_val("cont_end_state", state, 0);

    // spurious done in CAPT and CFG_INV must not change the sequence
    begin_frame(0, 0, 5, 5, 1, 1);
    do_start();
    run_to(0);
    check_frame(N);
    len2 = cyc - start_cyc;
    check_val("spur_frame_len", len2, len1);

    // randomized frames with a start pulse while busy
    for (int t = 0; t < 3; t++) begin
      br = BW'($urandom); bi = BW'($urandom); ram_add_real = br; ram_add_img = bi;
      begin_frame($urandom_range(0, 6), $urandom_range(0, 6),
                  $urandom_range(1, TMO - 1), $urandom_range(1, TMO - 1), 0, 0);
      do_start();
      ram_add_real = BW'($urandom); ram_add_img = BW'($urandom);
      repeat (20) step();
      start = 1'b1; step(); start = 1'b0;
      run_to(0);
      check_frame(N);
      check_val("rand_base", {fft_base_real, fft_base_img}, {br, bi});
    end

    // timeout in RUN_INV; abort leaves err set; reset clears it immediately
    begin_frame(0, 0, 3, -1, 0, 0);
    do_start();
    run_to(0);
    check_val("tmo_inv_state", state, 7);
    check_val("tmo_inv_cycles", st_cnt[5], TMO);
    abort = 1'b1; step(); abort = 1'b0;
    check_val("abort_err_state", state, 0);
    check_val("abort_err_kept", err, 1);
    sys_rst = 1'b1; #1;
    check_val("async_rst_err", err, 0);
    step();
    sys_rst = 1'b0;

    check_val("busy_decode", busy_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the shared FFT core in the spectrum path. On a start request it captures one frame of ADC samples into the sample buffer and runs the core forward. It then runs the same core inverse using the spectrum RAM, and streams the reconstructed frame out to the DAC playback buffer. It sits between the key/ADC front end and the FFT core plus buffers, in the `fft_clk` domain.

## Interface
Parameters:
- `N_LOG2`, 12: log2 of frame length N; frame length is 4096.
- `AD_W`, 10: ADC sample width.
- `ADDR_W`, 16: spectrum RAM base-address width.
- `TMO_CYC`, 65536: maximum cycles allowed waiting for `fft_done`.

Ports:
- `fft_clk`  in  1: sole clock.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request, from the debounced key.
- `abort`  in  1: level; forces the block to IDLE.
- `cont_mode`  in  1: when 1, restart capture automatically after playback.
- `ad_data`  in  AD_W: ADC sample, one per cycle.
- `ram_add_real`, `ram_add_img`  in  ADDR_W: spectrum RAM base addresses for real and imaginary parts.
- `cap_we`  out  1, `cap_addr`  out  N_LOG2, `cap_wdata`  out  AD_W: sample-buffer write port.
- `fft_cfg_valid`  out  1, `fft_cfg_ready`  in  1, `fft_inv`  out  1: core configuration handshake.
- `fft_base_real`, `fft_base_img`  out  ADDR_W: latched spectrum bases.
- `fft_done`  in  1: one-cycle completion pulse from the core.
- `play_en`  out  1, `play_addr`  out  N_LOG2: DAC playback read port.
- `busy`  out  1, `frame_done`  out  1 (pulse), `err`  out  1 (sticky), `state`  out  3.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE.
- State encoding: IDLE=0, CAPT=1, CFG_FWD=2, RUN_FWD=3, CFG_INV=4, RUN_INV=5, PLAY=6, ERR=7. `state` is the current encoding.
- `busy` = 1 in every state except IDLE and ERR.
- IDLE:
  - `start` moves to CAPT.
  - On that edge, latch `ram_add_real` and `ram_add_img` into `fft_base_real` and `fft_base_img`. They stay constant until the next accepted start.
- CAPT:
  - Each cycle, `cap_we`=1, `cap_wdata`=`ad_data` sampled on that edge, and `cap_addr` increments from 0.
  - After the write to address N-1, move to CFG_FWD.
  - Exactly N consecutive writes per frame, with no gaps.
- CFG_FWD / CFG_INV:
  - Hold `fft_cfg_valid`=1 with `fft_inv`=0 (CFG_FWD) or 1 (CFG_INV) stable until the cycle with `fft_cfg_ready`=1.
  - Then move to RUN_FWD or RUN_INV respectively.
  - `fft_cfg_valid` drops on the next edge.
- RUN_FWD / RUN_INV:
  - A timeout counter clears on entry.
  - `fft_done` moves RUN_FWD to CFG_INV and RUN_INV to PLAY.
  - If the counter reaches `TMO_CYC` with no `fft_done`, move to ERR.
- PLAY:
  - `play_en`=1 and `play_addr` counts 0..N-1.
  - After N-1, pulse `frame_done` for one cycle.
  - Then go to CAPT if `cont_mode`=1 (bases are not re-latched), otherwise to IDLE.
- ERR: `err`=1 and holds. `start` clears `err` and moves to IDLE; it does not start a frame.
- `abort`=1 in any state:
  - Next state is IDLE.
  - `cap_we`, `fft_cfg_valid` and `play_en` are 0 from the next edge.
  - `err` is unchanged.
- Boundary rules:
  - `start` while busy is ignored.
  - `abort` beats `start` and every other transition in the same cycle.
  - `fft_done` outside RUN_* is ignored and does not advance state.
  - `fft_done` in the same cycle the timeout count is reached counts as done, not error.
  - `cap_addr` and `play_addr` wrap N-1 to 0 only by leaving the state; they hold their last value otherwise.

## Timing
- `start` sampled high at edge k:
  - `state`=CAPT and `cap_addr`=0 after edge k+1.
  - First `cap_we` is visible in cycle k+1 and carries `ad_data` sampled at edge k+1.
- CAPT lasts exactly N cycles.
- CFG_* lasts at least 1 cycle, plus 1 cycle per cycle that ready is low.
- PLAY lasts exactly N cycles.
- `frame_done` is high during the cycle after the `play_addr`=N-1 cycle.
- Overhead with ready=1 and immediate done, excluding the two FFT runs: N (capture) + N (play) + 4 cycles.
- The timeout counter is 17 bits and saturates; it is sized for `TMO_CYC` ≤ 2^17-1.

## Structure
- Shared package `fft_pkg`: state encoding constants, `N_LOG2`, `AD_W` defaults.
- One sub-module, `fft_tmo_cnt`: the clearable saturating timeout counter with a `hit` output.
- FSM and address counters live in this block.

## Test plan
All scenarios use `N_LOG2`=4 (N=16) and `TMO_CYC`=32.
- `start` pulse, `ad_data` ramp 0..15, ready tied 1, `fft_done` 5 cycles after each cfg accept -> 16 writes, addr 0..15 with data 0..15; cfg seen with `fft_inv`=0 then 1; 16 play cycles; `frame_done` pulses once; `state` returns to 0.
- `fft_cfg_ready` held low 7 cycles in CFG_FWD -> `fft_cfg_valid` stays 1 for 8 cycles with `fft_inv` stable at 0; no state skip.
- No `fft_done` in RUN_FWD -> after 32 cycles `state`=7 and `err`=1; next `start` gives `err`=0 and `state`=0.
- `abort` asserted at the 10th capture cycle together with `start` -> IDLE next edge, `cap_we`=0; no further writes.
- `cont_mode`=1, base inputs changed mid-frame -> after PLAY, goes directly to CAPT; `fft_base_real`/`fft_base_img` retain the first latched values.
- Spurious `fft_done` during CAPT and CFG_INV -> ignored; sequence identical to scenario 1.
